median_window_5x5: RTL and testbench
====================================

# median_window_5x5

Streaming window generator that sits directly upstream of the 11-input median selector in the 5×5 recursive median filter. It accepts a raster-order pixel stream, buffers four full image lines, and maintains a 5×5 sliding window. For every interior window position it presents the 11 taps consumed by the selector, registered and qualified by a valid strobe. It also flags the last window of each frame.

## Interface
- IMG_W, default 640, image width in pixels (≥5).
- IMG_H, default 480, image height in lines (≥5).
- DW, default 8, pixel width in bits.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_pix is valid this cycle; there is no backpressure, so every valid pixel is accepted.
- in_pix  in  DW  input pixel, raster order, row 0 col 0 first.
- out_valid  out  1  pix1..pix11 hold a valid interior window.
- pix1..pix11  out  DW each  window taps (mapping in Operation).
- out_eof  out  1  high with out_valid on the last window of a frame.

## Operation
- **Counters.** col (0..IMG_W-1) and row (0..IMG_H-1) track the position of the accepted pixel.
  - col increments on each in_valid.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - At row=IMG_H-1 and col=IMG_W-1, both wrap to 0 and the next frame starts with no idle cycle required.
- **Line buffers.** Four line buffers of IMG_W×DW, synchronous read, are cascaded.
  - On each accept, line k's stored value at col is read and forwarded to line k+1.
  - in_pix is written into line 0 at col.
  - This yields the column (r-4..r, c) for accepted pixel (r,c).
- **Window register.** A 5×5 array shifts one column left per accepted pixel. The newest column enters at the right.
- **Window contents.** After pixel (r,c) the window holds rows r-4..r and cols c-4..c. The centre is (r-2,c-2). Let w[dr][dc] be the offset from centre, with dr,dc in -2..2.
- **Tap mapping.**
  - pix1..pix5 = w[0][-2..2] (pix3 is the centre).
  - pix6 = w[-2][0], pix7 = w[-1][0], pix8 = w[1][0], pix9 = w[2][0].
  - pix10 = w[-1][-1], pix11 = w[1][1].
- **Emission rule.** A window is emitted only when r≥4 and c≥4, so centres cover rows 2..IMG_H-3 and cols 2..IMG_W-3. Border pixels are not emitted; border pass-through is handled downstream.
- **Row wrap.** Stale line-buffer or window data from the previous row or frame never appears in an emitted window. This is guaranteed by the c≥4 and r≥4 gating.
- **End of frame.** out_eof = out_valid for the window generated by pixel (IMG_H-1, IMG_W-1).
- **Reset.** On rst:
  - col, row and the pipeline valid bits clear.
  - out_valid=0, out_eof=0, pix1..pix11=0.
  - Line-buffer RAM is not cleared.
  - rst mid-frame aborts the frame. The next accepted pixel is treated as (0,0).

## Timing
- **Latency.** Pixel (r,c) is sampled at edge k. When it qualifies, out_valid and its taps are visible after edge k+2 and last exactly one cycle: 1 cycle RAM read plus 1 cycle window/output register.
- **Idle cycles.** out_valid is low on cycles not produced by a qualifying accept. Taps hold their last value while out_valid is low.
- **Gaps.** in_valid may deassert for any number of cycles without affecting window contents. Throughput is one window per clk.
- **rst priority.** rst asserted at the same edge as in_valid discards that pixel. rst also cancels any in-flight valid.
- **Counter widths.** col uses $clog2(IMG_W) bits and row uses $clog2(IMG_H) bits. Wrap is explicit, never by overflow.

## Test plan
- **Ramp frame.** IMG_W=8, IMG_H=6, pixel=8r+c, continuous in_valid.
  - Required: exactly 8 out_valid pulses.
  - The first is 2 cycles after accepting (4,4), with pix1..pix11 = 16,17,18,19,20,2,10,26,34,9,27.
  - The last has pix3=29 and out_eof=1.
- **Random gaps.** Same frame with in_valid randomly low about 50% of cycles. Required: an identical tap sequence, each out_valid exactly 2 cycles after its qualifying accept.
- **Back-to-back frames.** Two consecutive 8×6 frames, the second using pixel=100+8r+c.
  - Required: no out_valid during second-frame rows 0–3.
  - The first second-frame window has pix3=118.
  - Exactly 16 pulses and 2 out_eof in total.
- **Reset mid-frame.** Assert rst for 1 cycle after pixel (4,5), then send a full frame.
  - Required: outputs read 0 the cycle after reset.
  - No window from the aborted frame is emitted afterwards.
  - The new frame reproduces the ramp-frame results.
- **Constant image.** All pixels 0xFF. Required: every emitted tap equals 0xFF and the DW-bit path has no truncation.

Source files
------------

// File: rtl/median_window_5x5.sv
// rtl/median_window_5x5.sv - 5x5 sliding window generator feeding the 11-tap median selector
module median_window_5x5 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_pix,
  output logic          out_valid,
  output logic [DW-1:0] pix1,
  output logic [DW-1:0] pix2,
  output logic [DW-1:0] pix3,
  output logic [DW-1:0] pix4,
  output logic [DW-1:0] pix5,
  output logic [DW-1:0] pix6,
  output logic [DW-1:0] pix7,
  output logic [DW-1:0] pix8,
  output logic [DW-1:0] pix9,
  output logic [DW-1:0] pix10,
  output logic [DW-1:0] pix11,
  output logic          out_eof
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(4);
  localparam logic [RW-1:0] ROW_MIN  = RW'(4);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          accept;

  assign accept = in_valid & ~rst;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Qualification and end-of-frame flags travel alongside the data pipeline.
  logic s1_vld_q, s1_qual_q, s1_eof_q;
  logic s2_qual_q, s2_eof_q;
  logic out_valid_q, out_eof_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_qual_q   <= 1'b0;
      s1_eof_q    <= 1'b0;
      s2_qual_q   <= 1'b0;
      s2_eof_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      s1_vld_q    <= in_valid;
      s1_qual_q   <= in_valid && (row_q >= ROW_MIN) && (col_q >= COL_MIN);
      s1_eof_q    <= in_valid && (row_q == ROW_LAST) && (col_q == COL_LAST);
      s2_qual_q   <= s1_qual_q;
      s2_eof_q    <= s1_eof_q;
      out_valid_q <= s2_qual_q;
      out_eof_q   <= s2_eof_q;
    end
  end

  logic [DW-1:0]            lb_q [4][IMG_W];
  logic [3:0][DW-1:0]       rd_q;
  logic [CW-1:0]            s1_col_q;
  logic [DW-1:0]            s1_pix_q;
  logic [4:0][4:0][DW-1:0]  win_q;

  // Line k is read on accept and its old value is written into line k+1 one
  // cycle later; the next accept is always at a different column, so no hazard.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][col_q] <= in_pix;
      rd_q[0]        <= lb_q[0][col_q];
      rd_q[1]        <= lb_q[1][col_q];
      rd_q[2]        <= lb_q[2][col_q];
      rd_q[3]        <= lb_q[3][col_q];
      s1_col_q       <= col_q;
      s1_pix_q       <= in_pix;
    end
    if (s1_vld_q && !rst) begin
      lb_q[1][s1_col_q] <= rd_q[0];
      lb_q[2][s1_col_q] <= rd_q[1];
      lb_q[3][s1_col_q] <= rd_q[2];
      win_q[0] <= {rd_q[3], win_q[0][4:1]};
      win_q[1] <= {rd_q[2], win_q[1][4:1]};
      win_q[2] <= {rd_q[1], win_q[2][4:1]};
      win_q[3] <= {rd_q[0], win_q[3][4:1]};
      win_q[4] <= {s1_pix_q, win_q[4][4:1]};
    end
  end

  logic [11*DW-1:0] taps_d, taps_q;

  // win_q[row][col]: row 0 is oldest line, col 4 is newest column, centre is [2][2].
  always_comb begin
    taps_d = {win_q[2][0], win_q[2][1], win_q[2][2], win_q[2][3], win_q[2][4],
              win_q[0][2], win_q[1][2], win_q[3][2], win_q[4][2],
              win_q[1][1], win_q[3][3]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q <= '0;
    end else if (s2_qual_q) begin
      taps_q <= taps_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_eof   = out_eof_q;
  assign pix1  = taps_q[11*DW-1 -: DW];
  assign pix2  = taps_q[10*DW-1 -: DW];
  assign pix3  = taps_q[9*DW-1  -: DW];
  assign pix4  = taps_q[8*DW-1  -: DW];
  assign pix5  = taps_q[7*DW-1  -: DW];
  assign pix6  = taps_q[6*DW-1  -: DW];
  assign pix7  = taps_q[5*DW-1  -: DW];
  assign pix8  = taps_q[4*DW-1  -: DW];
  assign pix9  = taps_q[3*DW-1  -: DW];
  assign pix10 = taps_q[2*DW-1  -: DW];
  assign pix11 = taps_q[DW-1    -: DW];

endmodule

// File: tb/tb_median_window_5x5.sv
// tb/tb_median_window_5x5.sv - scoreboard bench for median_window_5x5 on an 8x6 frame
module tb_median_window_5x5;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_pix = '0;
  logic out_valid, out_eof;
  logic [DW-1:0] pix1, pix2, pix3, pix4, pix5, pix6, pix7, pix8, pix9, pix10, pix11;

  median_window_5x5 #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pix(in_pix),
    .out_valid(out_valid),
    .pix1(pix1), .pix2(pix2), .pix3(pix3), .pix4(pix4), .pix5(pix5), .pix6(pix6),
    .pix7(pix7), .pix8(pix8), .pix9(pix9), .pix10(pix10), .pix11(pix11),
    .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [87:0] taps;
    bit          eof;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  img [H][W];
  logic [87:0] last_taps = '0;
  logic [87:0] dut_taps;
  int total = 0, bad = 0;
  int pulses = 0, eofs = 0;
  int tr = 0, tc = 0;
  bit mon_en = 0, first_chk = 0, ramp_last_chk = 0;
  int b2b_state = 0;

  localparam logic [87:0] RAMP_FIRST = 88'h10_11_12_13_14_02_0a_1a_22_09_1b;

  assign dut_taps = {pix1, pix2, pix3, pix4, pix5, pix6, pix7, pix8, pix9, pix10, pix11};

  task automatic chk(input string nm, input logic [87:0] act, input logic [87:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Window taps straight from the image: centre is two rows up and two columns left.
  function automatic logic [87:0] model_taps(int r, int c);
    int cr = r - 2;
    int cc = c - 2;
    return {img[cr][cc-2], img[cr][cc-1], img[cr][cc], img[cr][cc+1], img[cr][cc+2],
            img[cr-2][cc], img[cr-1][cc], img[cr+1][cc], img[cr+2][cc],
            img[cr-1][cc-1], img[cr+1][cc+1]};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        exp_t e;
        pulses++;
        if (out_eof) eofs++;
        if (sb.size() == 0) begin
          chk("spurious_valid", 88'(out_valid), 88'(0));
        end else begin
          e = sb.pop_front();
          chk("taps", dut_taps, e.taps);
          chk("eof", 88'(out_eof), 88'(e.eof));
          chk("latency_cycle", 88'(cyc), 88'(e.cyc));
          last_taps = e.taps;
        end
        if (first_chk) begin
          chk("ramp_first_window", dut_taps, RAMP_FIRST);
          first_chk = 0;
        end
        if (ramp_last_chk && out_eof) chk("ramp_last_pix3", 88'(pix3), 88'(29));
        if (b2b_state == 2) begin
          chk("frame2_first_pix3", 88'(pix3), 88'(118));
          b2b_state = 0;
        end else if (b2b_state == 1 && out_eof) begin
          b2b_state = 2;
        end
      end else begin
        chk("idle_hold_taps", dut_taps, last_taps);
        chk("idle_eof_low", 88'(out_eof), 88'(0));
      end
    end
  end

  task automatic idle();
    @(negedge clk); #1;
    in_valid = 1'b0;
    in_pix = 8'($urandom);
  endtask

  task automatic drive(input logic [7:0] p);
    exp_t e;
    @(negedge clk); #1;
    in_valid = 1'b1;
    in_pix = p;
    img[tr][tc] = p;
    if (tr >= 4 && tc >= 4) begin
      e.taps = model_taps(tr, tc);
      e.eof  = (tr == H - 1) && (tc == W - 1);
      e.cyc  = cyc + 3;
      sb.push_back(e);
    end
    if (tc == W - 1) begin
      tc = 0;
      tr = (tr == H - 1) ? 0 : tr + 1;
    end else begin
      tc++;
    end
  endtask

  // mode 0: ramp base+8r+c, 1: all 0xFF, 2: random pixels
  task automatic send_frame(input int mode, input int base, input bit gaps, input int npix);
    for (int i = 0; i < npix; i++) begin
      logic [7:0] p;
      if (gaps) begin
        for (int g = 0; g < 6 && $urandom_range(0, 1) == 1; g++) idle();
      end
      case (mode)
        0:       p = 8'(base + 8 * tr + tc);
        1:       p = 8'hFF;
        default: p = 8'($urandom);
      endcase
      drive(p);
    end
  endtask

  task automatic drain_check(input int exp_pulses, input int exp_eofs);
    repeat (8) idle();
    chk("scoreboard_empty", 88'(sb.size()), 88'(0));
    chk("pulse_count", 88'(pulses), 88'(exp_pulses));
    chk("eof_count", 88'(eofs), 88'(exp_eofs));
    pulses = 0;
    eofs = 0;
    first_chk = 0;
    ramp_last_chk = 0;
    b2b_state = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    tr = 0;
    tc = 0;
    last_taps = '0;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("reset_out_valid", 88'(out_valid), 88'(0));
    chk("reset_out_eof", 88'(out_eof), 88'(0));
    chk("reset_taps", dut_taps, 88'(0));
    pulses = 0;
    eofs = 0;
    mon_en = 1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    do_reset();

    first_chk = 1; ramp_last_chk = 1;
    send_frame(0, 0, 1'b0, W * H);
    drain_check(8, 1);

    first_chk = 1; ramp_last_chk = 1;
    send_frame(0, 0, 1'b1, W * H);
    drain_check(8, 1);

    b2b_state = 1;
    send_frame(0, 0, 1'b0, W * H);
    send_frame(0, 100, 1'b0, W * H);
    drain_check(16, 2);

    send_frame(0, 0, 1'b0, 4 * W + 6);
    do_reset();
    first_chk = 1; ramp_last_chk = 1;
    send_frame(0, 0, 1'b0, W * H);
    drain_check(8, 1);

    send_frame(1, 0, 1'b1, W * H);
    drain_check(8, 1);

    for (int f = 0; f < 3; f++) send_frame(2, 0, 1'b1, W * H);
    drain_check(24, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
